// File: rtl/montgomery_param.sv
// Parametrised bit-serial Montgomery multiplier.
// Computes result = A * B * 2^(-WIDTH) mod M for odd M and operands A, B < M.
// One radix-2 Montgomery step per ITER cycle, then a final conditional
// subtraction in SUB. Total WIDTH+1 cycles from the accepted start edge.
module montgomery_param #(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;

  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] regM;
  logic [WIDTH+1:0] regC;
  logic [CW-1:0]    cnt;

  // Step operands are carried at WIDTH+2 bits; regC < 2M keeps them from overflowing.
  logic [WIDTH+1:0] stepT;
  logic [WIDTH+1:0] stepU;
  logic             cGeM;
  logic [WIDTH-1:0] cMinusM;
  logic             lastIter;

  // Montgomery step and final-reduction arithmetic.
  always_comb begin
    stepT    = regC + (regA[0] ? {2'b00, regB} : '0);
    stepU    = stepT + (stepT[0] ? {2'b00, regM} : '0);
    cGeM     = (regC >= {2'b00, regM});
    // regC < 2M, so when regC >= M the difference fits in WIDTH bits.
    cMinusM  = regC[WIDTH-1:0] - regM;
    lastIter = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; abort outranks both iteration progress and SUB completion.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) nextState = ITER;
      end
      ITER: begin
        if (abort)         nextState = IDLE;
        else if (lastIter) nextState = SUB;
      end
      SUB: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath, and registered result/done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regA   <= '0;
      regB   <= '0;
      regM   <= '0;
      regC   <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            regA <= in_a;
            regB <= in_b;
            regM <= in_m;
            regC <= '0;
            cnt  <= '0;
          end
        end
        ITER: begin
          if (!abort) begin
            regC <= stepU >> 1;
            regA <= regA >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
        SUB: begin
          if (!abort) begin
            result <= cGeM ? cMinusM : regC[WIDTH-1:0];
            done   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Busy is a pure decode of the in-flight states.
  always_comb begin
    busy = (state == ITER) || (state == SUB);
  end

endmodule

// File: tb/tb_montgomery_param.sv
// Directed bench for montgomery_param: an 8-bit instance for handshake, timing
// and hand-computed vectors, plus a 1024-bit instance checked by an
// independent modular-arithmetic model.
module tb_montgomery_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          abort;

  logic          start8;
  logic [7:0]    a8, b8, m8, res8;
  logic          busy8, done8;

  logic          start1k;
  logic [1023:0] a1k, b1k, m1k, res1k;
  logic          busy1k, done1k;

  int nChk  = 0;
  int nFail = 0;

  montgomery_param #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .start  (start8),
    .abort  (abort),
    .in_a   (a8),
    .in_b   (b8),
    .in_m   (m8),
    .busy   (busy8),
    .result (res8),
    .done   (done8)
  );

  montgomery_param #(.WIDTH(1024)) dut1k (
    .clk    (clk),
    .resetn (resetn),
    .start  (start1k),
    .abort  (abort),
    .in_a   (a1k),
    .in_b   (b1k),
    .in_m   (m1k),
    .busy   (busy1k),
    .result (res1k),
    .done   (done1k)
  );

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    nChk++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // (x + y) mod m for x, y < m.
  function automatic logic [1023:0] modAdd(input logic [1023:0] x, input logic [1023:0] y,
                                           input logic [1023:0] m);
    logic [1024:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[1023:0];
  endfunction

  // a * b mod m by left-to-right double-and-add.
  function automatic logic [1023:0] mulMod(input logic [1023:0] a, input logic [1023:0] b,
                                           input logic [1023:0] m);
    logic [1023:0] x;
    x = '0;
    for (int i = 1023; i >= 0; i--) begin
      x = modAdd(x, x, m);
      if (b[i]) x = modAdd(x, a, m);
    end
    return x;
  endfunction

  // r * 2^1024 mod m.
  function automatic logic [1023:0] shiftUp(input logic [1023:0] r, input logic [1023:0] m);
    logic [1023:0] x;
    x = r;
    for (int i = 0; i < 1024; i++) x = modAdd(x, x, m);
    return x;
  endfunction

  // One 8-bit operation with optional mid-flight start pulse / abort.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                     input int pulseAt, input int abortAt, input bit abortWithStart,
                     output int lat, output int busyCnt, output int doneCnt);
    @(negedge clk);
    a8 = a; b8 = b; m8 = m;
    start8 = 1'b1;
    abort  = abortWithStart;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    abort  = 1'b0;
    lat = -1; busyCnt = 0; doneCnt = 0;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (busy8) busyCnt++;
      if (done8) begin
        doneCnt++;
        if (lat < 0) lat = n;
      end
      start8 = 1'b0;
      abort  = 1'b0;
      if (n == pulseAt) begin
        start8 = 1'b1;
        a8 = 8'd5; b8 = 8'd7;
      end
      if (n == abortAt) abort = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busyCnt, doneCnt, w;
    logic [1023:0] ra, rb, rm;

    resetn = 1'b0; abort = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    start1k = 1'b0; a1k = '0; b1k = '0; m1k = '0;
    #12;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", res8, 0);
    chk("rst_result1k", res1k, 0);
    @(negedge clk);
    resetn = 1'b1;

    // 5*7*2^-8 mod 13 = 1
    op8(8'd5, 8'd7, 8'd13, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("basic_lat", lat, 9);
    chk("basic_busy", busyCnt, 9);
    chk("basic_donecnt", doneCnt, 1);
    chk("basic_res", res8, 1);

    op8(8'd1, 8'd1, 8'd13, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("one_res", res8, 3);
    op8(8'd0, 8'd12, 8'd13, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("zero_res", res8, 0);
    chk("zero_lat", lat, 9);
    op8(8'd254, 8'd254, 8'd255, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("edge_res", res8, 1);

    // start and abort together in IDLE: start wins
    op8(8'd2, 8'd3, 8'd13, -1, -1, 1'b1, lat, busyCnt, doneCnt);
    chk("startabort_res", res8, 5);
    chk("startabort_lat", lat, 9);

    // mid-flight start pulse with different operands is ignored
    op8(8'd1, 8'd1, 8'd13, 4, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("ignstart_donecnt", doneCnt, 1);
    chk("ignstart_res", res8, 3);
    chk("ignstart_lat", lat, 9);

    op8(8'd5, 8'd7, 8'd13, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("pre_abort_res", res8, 1);
    // abort during ITER (iteration 4)
    op8(8'd1, 8'd1, 8'd13, -1, 4, 1'b0, lat, busyCnt, doneCnt);
    chk("abort_donecnt", doneCnt, 0);
    chk("abort_busy", busyCnt, 5);
    chk("abort_res", res8, 1);
    // abort during SUB
    op8(8'd1, 8'd1, 8'd13, -1, 8, 1'b0, lat, busyCnt, doneCnt);
    chk("abortsub_donecnt", doneCnt, 0);
    chk("abortsub_busy", busyCnt, 9);
    chk("abortsub_res", res8, 1);

    // back-to-back: second start issued in the done cycle
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    w = -1;
    do begin @(negedge clk); w++; end while (!done8 && w < 20);
    chk("b2b_lat1", w, 9);
    chk("b2b_res1", res8, 1);
    chk("b2b_busy_in_done", busy8, 0);
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    w = -1;
    do begin @(negedge clk); w++; end while (!done8 && w < 20);
    chk("b2b_lat2", w, 9);
    chk("b2b_res2", res8, 5);

    // asynchronous reset mid-ITER
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_res", res8, 0);
    @(negedge clk);
    resetn = 1'b1;
    op8(8'd5, 8'd7, 8'd13, -1, -1, 1'b0, lat, busyCnt, doneCnt);
    chk("post_rst_res", res8, 1);
    chk("post_rst_lat", lat, 9);

    // 1024-bit instance: M odd with top bit set, A, B below 2^1023 < M
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 32; j++) begin
        rm[j*32 +: 32] = $urandom;
        ra[j*32 +: 32] = $urandom;
        rb[j*32 +: 32] = $urandom;
      end
      rm[1023] = 1'b1; rm[0] = 1'b1;
      ra[1023] = 1'b0; rb[1023] = 1'b0;
      if (k == 0) ra = '0;
      @(negedge clk);
      a1k = ra; b1k = rb; m1k = rm; start1k = 1'b1;
      @(posedge clk);
      #1 start1k = 1'b0;
      lat = -1; doneCnt = 0;
      for (int n = 0; n <= 1027; n++) begin
        if (n > 0) @(posedge clk);
        @(negedge clk);
        if (done1k) begin
          doneCnt++;
          if (lat < 0) lat = n;
        end
      end
      chk("big_lat", lat, 1025);
      chk("big_donecnt", doneCnt, 1);
      chk("big_reduced", (res1k < rm), 1);
      chk("big_value", shiftUp(res1k, rm), mulMod(ra, rb, rm));
    end

    $display("%0d/%0d checks passed", nChk - nFail, nChk);
    $finish;
  end

endmodule
